// File: rtl/gpio_in_debounce.sv
// Pad input conditioner: synchronises IO_NUM async inputs into PCLK and debounces
// each bit against a shared prescaled tick, emitting registered rise/fall pulses.

module gpio_db_lane #(
   parameter int   DB_TICKS = 4,
   parameter logic RST_LVL  = 1'b0
) (
   input  logic PCLK,
   input  logic PRESETN,
   input  logic en_i,
   input  logic tick_i,
   input  logic s_i,
   output logic lvl_o,
   output logic rise_o,
   output logic fall_o
);

   localparam logic [3:0] TERM = 4'(DB_TICKS - 1);

   logic [3:0] cnt_q, cnt_d;
   logic       lvl_q, lvl_d;
   logic       rise_q, rise_d;
   logic       fall_q, fall_d;

   // Any cycle where the synchronised level matches the accepted one restarts qualification.
   always_comb begin
      cnt_d  = cnt_q;
      lvl_d  = lvl_q;
      rise_d = 1'b0;
      fall_d = 1'b0;
      if (!en_i || (s_i == lvl_q)) begin
         cnt_d = '0;
      end else if (tick_i) begin
         if (cnt_q == TERM) begin
            lvl_d  = s_i;
            cnt_d  = '0;
            rise_d = s_i;
            fall_d = ~s_i;
         end else begin
            cnt_d = cnt_q + 4'd1;
         end
      end
   end

   always_ff @(posedge PCLK or negedge PRESETN) begin
      if (!PRESETN) begin
         cnt_q  <= '0;
         lvl_q  <= RST_LVL;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         lvl_q  <= lvl_d;
         rise_q <= rise_d;
         fall_q <= fall_d;
      end
   end

   assign lvl_o  = lvl_q;
   assign rise_o = rise_q;
   assign fall_o = fall_q;

endmodule

module gpio_in_debounce #(
   parameter int                IO_NUM      = 8,
   parameter int                SYNC_STAGES = 2,
   parameter int                PRESCALE    = 100,
   parameter int                DB_TICKS    = 4,
   parameter logic [IO_NUM-1:0] RESET_VAL   = '0
) (
   input  logic              PCLK,
   input  logic              PRESETN,
   input  logic              EN,
   input  logic [IO_NUM-1:0] PAD_IN,
   output logic [IO_NUM-1:0] GPIO_IN,
   output logic [IO_NUM-1:0] RISE,
   output logic [IO_NUM-1:0] FALL,
   output logic              ANY_EDGE
);

   localparam logic [15:0] PRE_LAST = 16'(PRESCALE - 1);

   logic [SYNC_STAGES-1:0][IO_NUM-1:0] sync_q;
   logic [IO_NUM-1:0]                  s;
   logic [15:0]                        pre_q, pre_d;
   logic                               tick;
   logic                               any_q;

   always_ff @(posedge PCLK or negedge PRESETN) begin
      if (!PRESETN) sync_q <= {SYNC_STAGES{RESET_VAL}};
      else          sync_q <= {sync_q[SYNC_STAGES-2:0], PAD_IN};
   end

   assign s = sync_q[SYNC_STAGES-1];

   // Prescaler parks at 0 while disabled so a re-enable always starts a full period.
   assign tick = EN && (pre_q == PRE_LAST);

   always_comb begin
      pre_d = pre_q + 16'd1;
      if (!EN || tick) pre_d = '0;
   end

   always_ff @(posedge PCLK or negedge PRESETN) begin
      if (!PRESETN) pre_q <= '0;
      else          pre_q <= pre_d;
   end

   for (genvar i = 0; i < IO_NUM; i++) begin : g_lane
      gpio_db_lane #(
         .DB_TICKS (DB_TICKS),
         .RST_LVL  (RESET_VAL[i])
      ) u_lane (
         .PCLK    (PCLK),
         .PRESETN (PRESETN),
         .en_i    (EN),
         .tick_i  (tick),
         .s_i     (s[i]),
         .lvl_o   (GPIO_IN[i]),
         .rise_o  (RISE[i]),
         .fall_o  (FALL[i])
      );
   end

   always_ff @(posedge PCLK or negedge PRESETN) begin
      if (!PRESETN) any_q <= 1'b0;
      else          any_q <= |(RISE | FALL);
   end

   assign ANY_EDGE = any_q;

endmodule

// File: tb/tb_gpio_in_debounce.sv
// Scoreboard bench: two instances (PRESCALE 1 and 4); expected edge events are queued
// when stimulus is driven and matched against each pulse the DUTs produce.

module tb_gpio_in_debounce;

   logic       PCLK = 1'b0;
   logic       PRESETN;
   logic       en1, en4;
   logic [7:0] pad1, pad4;
   logic [7:0] gi1, ri1, fa1, gi4, ri4, fa4;
   logic       any1, any4;

   always #5 PCLK = ~PCLK;

   gpio_in_debounce #(.IO_NUM(8), .SYNC_STAGES(2), .PRESCALE(1), .DB_TICKS(4), .RESET_VAL(8'h00)) u_dut1 (
      .PCLK(PCLK), .PRESETN(PRESETN), .EN(en1), .PAD_IN(pad1),
      .GPIO_IN(gi1), .RISE(ri1), .FALL(fa1), .ANY_EDGE(any1));

   gpio_in_debounce #(.IO_NUM(8), .SYNC_STAGES(2), .PRESCALE(4), .DB_TICKS(4), .RESET_VAL(8'h00)) u_dut4 (
      .PCLK(PCLK), .PRESETN(PRESETN), .EN(en4), .PAD_IN(pad4),
      .GPIO_IN(gi4), .RISE(ri4), .FALL(fa4), .ANY_EDGE(any4));

   typedef struct {
      string      tag;
      int         dut;
      int         t0;
      int         lo;
      int         hi;
      logic [7:0] lvl;
      logic [7:0] rise;
      logic [7:0] fall;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_err = 0;
   int   cyc   = 0;
   int   rel_cyc = 0;
   logic [3:0] lat_mask = '0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_cmp++;
      if (obs !== exp_v) begin
         n_err++;
         $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp_v);
      end
   endtask

   always @(posedge PCLK) cyc <= cyc + 1;

   logic [1:0][7:0] gi_a, ri_a, fa_a;
   logic [1:0]      any_a;
   logic [1:0]      prev_ev = '0;
   exp_t            e;
   int              lat;
   assign gi_a  = {gi4, gi1};
   assign ri_a  = {ri4, ri1};
   assign fa_a  = {fa4, fa1};
   assign any_a = {any4, any1};

   always @(negedge PCLK) begin
      if (!PRESETN) begin
         prev_ev = '0;
      end else begin
         for (int d = 0; d < 2; d++) begin
            if ((ri_a[d] | fa_a[d]) != 8'h00) begin
               if (exp_q.size() == 0) begin
                  chk($sformatf("unexpected_evt_dut%0d_cyc%0d", d, cyc), {8'h0, ri_a[d], fa_a[d], gi_a[d]}, 32'h0);
               end else begin
                  e   = exp_q.pop_front();
                  lat = cyc - e.t0;
                  chk({e.tag, "_dut"},  d,        e.dut);
                  chk({e.tag, "_lvl"},  gi_a[d],  e.lvl);
                  chk({e.tag, "_rise"}, ri_a[d],  e.rise);
                  chk({e.tag, "_fall"}, fa_a[d],  e.fall);
                  chk($sformatf("%s_lat%0d_in_%0d..%0d", e.tag, lat, e.lo, e.hi),
                      (lat >= e.lo && lat <= e.hi), 1);
                  if (d == 1 && e.fall != 8'h00 && lat >= 15 && lat <= 18) lat_mask[lat-15] = 1'b1;
               end
            end
            if (prev_ev[d] || any_a[d]) chk($sformatf("any_edge_dut%0d", d), any_a[d], prev_ev[d]);
            prev_ev[d] = ((ri_a[d] | fa_a[d]) != 8'h00);
         end
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(negedge PCLK);
         #1;
      end
   endtask

   task automatic push(input string tag, input int dut, input int lo, input int hi,
                       input logic [7:0] lvl, input logic [7:0] rise, input logic [7:0] fall);
      exp_t x;
      x.tag = tag; x.dut = dut; x.t0 = cyc; x.lo = lo; x.hi = hi;
      x.lvl = lvl; x.rise = rise; x.fall = fall;
      exp_q.push_back(x);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      PRESETN = 1'b0; en1 = 1'b1; en4 = 1'b1; pad1 = 8'hFF; pad4 = 8'h00;

      // Reset with a high pad held: nothing may propagate.
      step(3);
      chk("rst_gpio", gi1, 8'h00);
      chk("rst_rise", ri1, 8'h00);
      chk("rst_fall", fa1, 8'h00);
      chk("rst_any",  any1, 1'b0);
      PRESETN = 1'b1; rel_cyc = cyc;
      push("rst_rise_ff", 0, 6, 6, 8'hFF, 8'hFF, 8'h00);
      step(10);
      pad1 = 8'h00;
      push("all_fall", 0, 6, 6, 8'h00, 8'h00, 8'hFF);
      step(10);

      // 3-cycle glitch rejected, 4-cycle pulse accepted.
      pad1 = 8'h01; step(3); pad1 = 8'h00;
      step(10);
      chk("glitch3_gpio", gi1, 8'h00);
      pad1 = 8'h01;
      push("pulse4_rise", 0, 6, 6, 8'h01, 8'h01, 8'h00);
      step(4); pad1 = 8'h00;
      push("pulse4_fall", 0, 6, 6, 8'h00, 8'h00, 8'h01);
      step(12);

      // Two bits swapping in one step update in the same cycle.
      pad1 = 8'h01;
      push("simul_pre", 0, 6, 6, 8'h01, 8'h01, 8'h00);
      step(10);
      pad1 = 8'h02;
      push("simul_swap", 0, 6, 6, 8'h02, 8'h02, 8'h01);
      step(10);
      pad1 = 8'h00;
      push("simul_clr", 0, 6, 6, 8'h00, 8'h00, 8'h02);
      step(10);

      // Enable dropped for one cycle after two ticks restarts qualification.
      pad1 = 8'h01;
      push("en_restart", 0, 9, 9, 8'h01, 8'h01, 8'h00);
      step(4); en1 = 1'b0;
      step(1); en1 = 1'b1;
      step(10);
      chk("en_gpio", gi1, 8'h01);
      pad1 = 8'h00;
      push("en_fall", 0, 6, 6, 8'h00, 8'h00, 8'h01);
      step(10);

      // Reset with cnt=3 on bit 2 clears outputs asynchronously.
      pad1 = 8'h03;
      push("mid_pre", 0, 6, 6, 8'h03, 8'h03, 8'h00);
      step(10);
      pad1 = 8'h07;
      step(5);
      PRESETN = 1'b0;
      #1;
      chk("midrst_gpio", gi1, 8'h00);
      chk("midrst_rise", ri1, 8'h00);
      chk("midrst_fall", fa1, 8'h00);
      chk("midrst_any",  any1, 1'b0);
      step(2);
      PRESETN = 1'b1; rel_cyc = cyc;
      push("mid_requal", 0, 6, 6, 8'h07, 8'h07, 8'h00);
      step(10);
      pad1 = 8'h00;
      push("mid_clr", 0, 6, 6, 8'h00, 8'h00, 8'h07);
      step(10);

      // Prescaled timing across all four prescaler phases.
      pad4 = 8'hFF;
      push("p4_all_rise", 1, 15, 18, 8'hFF, 8'hFF, 8'h00);
      step(22);
      for (int p = 0; p < 4; p++) begin
         for (int k = 0; k < 4; k++) if (((cyc - rel_cyc) % 4) != p) step(1);
         pad4 = 8'hF7;
         push($sformatf("p4_fall_ph%0d", p), 1, 15, 18, 8'hF7, 8'h00, 8'h08);
         step(22);
         pad4 = 8'hFF;
         push($sformatf("p4_rise_ph%0d", p), 1, 15, 18, 8'hFF, 8'h08, 8'h00);
         step(22);
      end
      chk("p4_phase_cover", lat_mask, 4'hF);
      chk("queue_drained", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
